// File: rtl/ysyx_210544_csr_file.sv
// ---------------------------------------------------------------------------
// ysyx_210544_csr_file
//   Machine-mode CSR register file. Responds to the CSR access port of the
//   exception unit: combinational reads, writes registered at the rising edge
//   through per-CSR write masks. Also runs mcycle/minstret, samples the CLINT
//   timer line into mip.MTIP and raises a registered timer-interrupt-pending
//   flag used to start trap entry.
//
//   Optional feature macro: YSYX_210544_CSR_COUNTERS_EN
//     defined   : mcycle (0xB00) and minstret (0xB02) counters implemented.
//     undefined : no counter flops; 0xB00/0xB02 read 0, ignore writes and are
//                 not flagged illegal; i_instret is unused.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_csr_addr          12-bit CSR address
//   i_csr_ren/i_csr_wen read / write enables
//   i_csr_wdata         64-bit write data
//   o_csr_rdata         read data (0 when ren is low)
//   o_csr_illegal       unmapped CSR address, valid while ren|wen
//   i_instret           one-cycle pulse per retired instruction
//   i_timer_int         level timer interrupt from CLINT
//   o_int_pend          registered mstatus.MIE & mie.MTIE & mip.MTIP
//   o_mtvec             current mtvec
// ---------------------------------------------------------------------------
module ysyx_210544_csr_file #(
    parameter logic [63:0] HARTID   = 64'd0,
    parameter logic [63:0] MISA_VAL = 64'h8000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_csr_addr,
    input  logic        i_csr_ren,
    input  logic        i_csr_wen,
    input  logic [63:0] i_csr_wdata,
    output logic [63:0] o_csr_rdata,
    output logic        o_csr_illegal,
    input  logic        i_instret,
    input  logic        i_timer_int,
    output logic        o_int_pend,
    output logic [63:0] o_mtvec
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    // Writable bits: MIE, MPIE, MPP, FS
    localparam logic [63:0] MSTATUS_MASK = 64'h0000_0000_0000_7888;
    localparam logic [63:0] MSTATUS_RST  = 64'h0000_0000_0000_1800;
    localparam logic [63:0] MIE_MASK     = 64'h0000_0000_0000_0888;
    localparam logic [63:0] MTVEC_MASK   = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] MEPC_MASK    = 64'hFFFF_FFFF_FFFF_FFFC;

    logic [63:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic        mtip_q;
    logic        int_pend_q;
    logic [63:0] mcycle_rd, minstret_rd;

    logic [63:0] rd_val;
    logic        addr_hit;

    // Only the masked bits are ever stored, so unwritable bits stay 0 and
    // the stored value can be returned directly on reads.
    wire wr_mstatus  = i_csr_wen && (i_csr_addr == A_MSTATUS);
    wire wr_mie      = i_csr_wen && (i_csr_addr == A_MIE);
    wire wr_mtvec    = i_csr_wen && (i_csr_addr == A_MTVEC);
    wire wr_mscratch = i_csr_wen && (i_csr_addr == A_MSCRATCH);
    wire wr_mepc     = i_csr_wen && (i_csr_addr == A_MEPC);
    wire wr_mcause   = i_csr_wen && (i_csr_addr == A_MCAUSE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= MSTATUS_RST;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtip_q     <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            if (wr_mstatus)  mstatus_q  <= i_csr_wdata & MSTATUS_MASK;
            if (wr_mie)      mie_q      <= i_csr_wdata & MIE_MASK;
            if (wr_mtvec)    mtvec_q    <= i_csr_wdata & MTVEC_MASK;
            if (wr_mscratch) mscratch_q <= i_csr_wdata;
            if (wr_mepc)     mepc_q     <= i_csr_wdata & MEPC_MASK;
            if (wr_mcause)   mcause_q   <= i_csr_wdata;
            mtip_q     <= i_timer_int;
            // Built from the current register values, so MTIP adds one cycle
            // and the flag appears two edges after i_timer_int rises.
            int_pend_q <= mstatus_q[3] & mie_q[7] & mtip_q;
        end
    end

`ifdef YSYX_210544_CSR_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
    wire wr_mcycle   = i_csr_wen && (i_csr_addr == A_MCYCLE);
    wire wr_minstret = i_csr_wen && (i_csr_addr == A_MINSTRET);

    // A port write overrides that cycle's increment; the adds wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (wr_mcycle)      mcycle_q <= i_csr_wdata;
            else                mcycle_q <= mcycle_q + 64'd1;
            if (wr_minstret)    minstret_q <= i_csr_wdata;
            else if (i_instret) minstret_q <= minstret_q + 64'd1;
        end
    end

    assign mcycle_rd   = mcycle_q;
    assign minstret_rd = minstret_q;
`else
    logic unused_instret;
    assign unused_instret = i_instret;
    assign mcycle_rd      = '0;
    assign minstret_rd    = '0;
`endif

    // NOTE: defaults are assigned before the case so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        rd_val   = '0;
        addr_hit = 1'b1;
        case (i_csr_addr)
            A_MSTATUS:  rd_val = {(mstatus_q[14:13] == 2'b11), mstatus_q[62:0]};
            A_MISA:     rd_val = MISA_VAL;
            A_MIE:      rd_val = mie_q;
            A_MTVEC:    rd_val = mtvec_q;
            A_MSCRATCH: rd_val = mscratch_q;
            A_MEPC:     rd_val = mepc_q;
            A_MCAUSE:   rd_val = mcause_q;
            A_MIP:      rd_val = {56'd0, mtip_q, 7'd0};
            A_MCYCLE:   rd_val = mcycle_rd;
            A_MINSTRET: rd_val = minstret_rd;
            A_MHARTID:  rd_val = HARTID;
            default:    addr_hit = 1'b0;
        endcase
    end

    assign o_csr_rdata   = i_csr_ren ? rd_val : '0;
    assign o_csr_illegal = (i_csr_ren | i_csr_wen) & ~addr_hit;
    assign o_int_pend    = int_pend_q;
    assign o_mtvec       = mtvec_q;

endmodule

// File: tb/tb_ysyx_210544_csr_file.sv
// ---------------------------------------------------------------------------
// tb_ysyx_210544_csr_file
//   Directed self-checking bench for ysyx_210544_csr_file. Inputs are driven
//   at the falling edge; outputs are sampled 1 time unit after it, well away
//   from the rising edge. Every stimulus task starts and ends at a falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_210544_csr_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] i_csr_addr = '0;
    logic        i_csr_ren = 1'b0;
    logic        i_csr_wen = 1'b0;
    logic [63:0] i_csr_wdata = '0;
    logic [63:0] o_csr_rdata;
    logic        o_csr_illegal;
    logic        i_instret = 1'b0;
    logic        i_timer_int = 1'b0;
    logic        o_int_pend;
    logic [63:0] o_mtvec;

    int tests = 0;
    int fails = 0;

    ysyx_210544_csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .i_csr_addr   (i_csr_addr),
        .i_csr_ren    (i_csr_ren),
        .i_csr_wen    (i_csr_wen),
        .i_csr_wdata  (i_csr_wdata),
        .o_csr_rdata  (o_csr_rdata),
        .o_csr_illegal(o_csr_illegal),
        .i_instret    (i_instret),
        .i_timer_int  (i_timer_int),
        .o_int_pend   (o_int_pend),
        .o_mtvec      (o_mtvec)
    );

    always #5 clk = ~clk;

    task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
        i_csr_addr  = addr;
        i_csr_wdata = data;
        i_csr_wen   = 1'b1;
        @(negedge clk);
        i_csr_wen   = 1'b0;
        i_csr_wdata = '0;
    endtask

    task automatic csr_read(input logic [11:0] addr, output logic [63:0] data,
                            output logic illegal);
        i_csr_addr = addr;
        i_csr_ren  = 1'b1;
        #1;
        data      = o_csr_rdata;
        illegal   = o_csr_illegal;
        i_csr_ren = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic        ill;
        tests++;
        if (o_int_pend !== 1'b0) begin
            fails++;
            $display("FAIL reset_int_pend: got %b want 0", o_int_pend);
        end
        csr_read(12'h300, d, ill);
        tests++;
        if (d !== 64'h1800 || ill !== 1'b0) begin
            fails++;
            $display("FAIL reset_mstatus: got %h/%b want 1800/0", d, ill);
        end
        csr_read(12'h301, d, ill);
        tests++;
        if (d !== 64'h8000_0000_0000_0100) begin
            fails++;
            $display("FAIL misa: got %h want 8000000000000100", d);
        end
        csr_read(12'hF14, d, ill);
        tests++;
        if (d !== 64'h0 || ill !== 1'b0) begin
            fails++;
            $display("FAIL mhartid: got %h/%b want 0/0", d, ill);
        end
        csr_read(12'h305, d, ill);
        tests++;
        if (d !== 64'h0 || o_mtvec !== 64'h0) begin
            fails++;
            $display("FAIL reset_mtvec: got %h/%h want 0/0", d, o_mtvec);
        end
    endtask

    task automatic test_write_masks();
        logic [63:0] d;
        logic        ill;
        csr_write(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(12'h300, d, ill);
        tests++;
        if (d !== 64'h8000_0000_0000_7888) begin
            fails++;
            $display("FAIL mstatus_mask: got %h want 8000000000007888", d);
        end
        // FS=01 -> SD must read 0
        csr_write(12'h300, 64'h2000);
        csr_read(12'h300, d, ill);
        tests++;
        if (d !== 64'h2000) begin
            fails++;
            $display("FAIL mstatus_sd_clear: got %h want 2000", d);
        end
        csr_write(12'h341, 64'h8000_0013);
        csr_read(12'h341, d, ill);
        tests++;
        if (d !== 64'h8000_0010) begin
            fails++;
            $display("FAIL mepc_mask: got %h want 80000010", d);
        end
        csr_write(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(12'h304, d, ill);
        tests++;
        if (d !== 64'h888) begin
            fails++;
            $display("FAIL mie_mask: got %h want 888", d);
        end
        csr_write(12'h305, 64'hFFFF_FFFF_FFFF_FFFF);
        csr_read(12'h305, d, ill);
        tests++;
        if (d !== 64'hFFFF_FFFF_FFFF_FFFD || o_mtvec !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            fails++;
            $display("FAIL mtvec_mask: got %h/%h want fffffffffffffffd", d, o_mtvec);
        end
        csr_write(12'h301, 64'h0);
        csr_read(12'h301, d, ill);
        tests++;
        if (d !== 64'h8000_0000_0000_0100 || ill !== 1'b0) begin
            fails++;
            $display("FAIL misa_ro: got %h/%b want 8000000000000100/0", d, ill);
        end
        csr_read(12'h344, d, ill);
        tests++;
        if (d !== 64'h0) begin
            fails++;
            $display("FAIL mip_idle: got %h want 0", d);
        end
        // ren low -> rdata forced to 0 even for a nonzero CSR
        i_csr_addr = 12'h301;
        #1;
        tests++;
        if (o_csr_rdata !== 64'h0 || o_csr_illegal !== 1'b0) begin
            fails++;
            $display("FAIL ren_low: got %h/%b want 0/0", o_csr_rdata, o_csr_illegal);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        logic        ill;
        csr_write(12'h342, 64'h1111);
        // same-cycle read and write: pre-write value on rdata
        i_csr_addr  = 12'h342;
        i_csr_wdata = 64'h2222;
        i_csr_wen   = 1'b1;
        i_csr_ren   = 1'b1;
        #1;
        tests++;
        if (o_csr_rdata !== 64'h1111) begin
            fails++;
            $display("FAIL rw_same_cycle: got %h want 1111", o_csr_rdata);
        end
        @(negedge clk);
        i_csr_wen = 1'b0;
        i_csr_ren = 1'b0;
        csr_read(12'h342, d, ill);
        tests++;
        if (d !== 64'h2222) begin
            fails++;
            $display("FAIL rw_after: got %h want 2222", d);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] d;
        logic        ill;
        csr_write(12'h340, 64'hDEAD_BEEF_0000_0001);
        csr_read(12'h7C0, d, ill);
        tests++;
        if (d !== 64'h0 || ill !== 1'b1) begin
            fails++;
            $display("FAIL illegal_read: got %h/%b want 0/1", d, ill);
        end
        i_csr_addr = 12'h7C0;
        #1;
        tests++;
        if (o_csr_illegal !== 1'b0) begin
            fails++;
            $display("FAIL illegal_idle: got %b want 0", o_csr_illegal);
        end
        i_csr_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        i_csr_wen   = 1'b1;
        #1;
        tests++;
        if (o_csr_illegal !== 1'b1) begin
            fails++;
            $display("FAIL illegal_write_flag: got %b want 1", o_csr_illegal);
        end
        @(negedge clk);
        i_csr_wen = 1'b0;
        csr_read(12'h340, d, ill);
        tests++;
        if (d !== 64'hDEAD_BEEF_0000_0001) begin
            fails++;
            $display("FAIL illegal_write_ignored: got %h want deadbeef00000001", d);
        end
        csr_read(12'h300, d, ill);
        tests++;
        if (d !== 64'h2000) begin
            fails++;
            $display("FAIL illegal_write_mstatus: got %h want 2000", d);
        end
    endtask

    task automatic test_timer_int();
        logic [63:0] d;
        logic        ill;
        logic        exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        csr_write(12'h300, 64'h8);
        csr_write(12'h304, 64'h80);
        i_timer_int = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) i_timer_int = 1'b0;
            @(negedge clk);
            #1;
            tests++;
            if (o_int_pend !== exp_seq[i]) begin
                fails++;
                $display("FAIL int_pend_cycle%0d: got %b want %b", i, o_int_pend, exp_seq[i]);
            end
        end
        @(negedge clk);
        i_timer_int = 1'b1;
        @(negedge clk);
        csr_read(12'h344, d, ill);
        tests++;
        if (d !== 64'h80) begin
            fails++;
            $display("FAIL mip_mtip: got %h want 80", d);
        end
        i_timer_int = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_counters();
        logic [63:0] d;
        logic        ill;
`ifdef YSYX_210544_CSR_COUNTERS_EN
        logic [63:0] exp_cyc [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                                     64'h0, 64'h1};
        csr_write(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            csr_read(12'hB00, d, ill);
            tests++;
            if (d !== exp_cyc[i]) begin
                fails++;
                $display("FAIL mcycle_wrap%0d: got %h want %h", i, d, exp_cyc[i]);
            end
        end
        i_instret = 1'b1;
        csr_write(12'hB02, 64'd5);
        i_instret = 1'b0;
        csr_read(12'hB02, d, ill);
        tests++;
        if (d !== 64'd5) begin
            fails++;
            $display("FAIL minstret_write_wins: got %h want 5", d);
        end
        i_instret = 1'b1;
        @(negedge clk);
        i_instret = 1'b0;
        @(negedge clk);
        csr_read(12'hB02, d, ill);
        tests++;
        if (d !== 64'd6) begin
            fails++;
            $display("FAIL minstret_inc: got %h want 6", d);
        end
`else
        csr_write(12'hB00, 64'h1234);
        for (int i = 0; i < 3; i++) begin
            csr_read(12'hB00, d, ill);
            tests++;
            if (d !== 64'h0 || ill !== 1'b0) begin
                fails++;
                $display("FAIL mcycle_absent%0d: got %h/%b want 0/0", i, d, ill);
            end
        end
        i_instret = 1'b1;
        csr_write(12'hB02, 64'h55);
        i_instret = 1'b0;
        csr_read(12'hB02, d, ill);
        tests++;
        if (d !== 64'h0 || ill !== 1'b0) begin
            fails++;
            $display("FAIL minstret_absent: got %h/%b want 0/0", d, ill);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        logic [63:0] d;
        logic        ill;
        i_csr_addr  = 12'h340;
        i_csr_wdata = 64'hAAAA;
        i_csr_wen   = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
        i_csr_wen = 1'b0;
        #1;
        tests++;
        if (o_mtvec !== 64'h0 || o_int_pend !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h/%b want 0/0", o_mtvec, o_int_pend);
        end
        @(negedge clk);
        rst = 1'b1;
        csr_read(12'h340, d, ill);
        tests++;
        if (d !== 64'h0) begin
            fails++;
            $display("FAIL reset_mid_write_dropped: got %h want 0", d);
        end
        csr_read(12'h300, d, ill);
        tests++;
        if (d !== 64'h1800) begin
            fails++;
            $display("FAIL reset_mid_mstatus: got %h want 1800", d);
        end
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_write_masks();
        test_back_to_back();
        test_illegal();
        test_timer_int();
        test_counters();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary, tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
